clk_burst_gen: RTL and testbench

//  Programmable clock generator, successor to the fixed/dynamic-ratio divider. Produces a divided clock

---
 rtl/clk_gen_pkg.sv | 13 +
 rtl/phase_cnt.sv | 36 +++
 rtl/clk_burst_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_clk_burst_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared encodings for the burst clock generator.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH_A = 2'd1,
        ST_PH_B = 2'd2
    } state_e;

    localparam logic MODE_FREE  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter timing one clock phase; zero flag marks the last tick.
module phase_cnt #(
    parameter int unsigned CNT_W = 28
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over decrement; holds at zero until reloaded.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/clk_burst_gen.sv
// Programmable divided-clock generator with burst/free-run modes and
// period-boundary reconfiguration.
module clk_burst_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W      = 28,
    parameter int unsigned BURST_W    = 16,
    parameter logic        IDLE_LEVEL = 1'b1,
    parameter int unsigned DEF_HIGH   = 10,
    parameter int unsigned DEF_LOW    = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [CNT_W-1:0]   cfg_high_i,
    input  logic [CNT_W-1:0]   cfg_low_i,
    input  logic               cfg_valid_i,
    input  logic               mode_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               start_i,
    input  logic               stop_i,
    output logic               clk_o,
    output logic               rise_stb_o,
    output logic               fall_stb_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               cfg_err_o
);

    state_e             state_q, state_d;
    logic               level_q, level_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   sh_high_q, sh_high_d;
    logic [CNT_W-1:0]   sh_low_q, sh_low_d;
    logic [CNT_W-1:0]   pend_high_q, pend_high_d;
    logic [CNT_W-1:0]   pend_low_q, pend_low_d;
    logic               pend_v_q, pend_v_d;
    logic               mode_q, mode_d;
    logic [BURST_W-1:0] blen_q, blen_d;
    logic [BURST_W-1:0] per_q, per_d;
    logic               stop_q, stop_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero_c;

    logic [CNT_W-1:0]   cap_high, cap_low;
    logic [CNT_W-1:0]   nxt_high, nxt_low;
    logic [CNT_W-1:0]   a_ticks_nxt, b_ticks;
    logic [BURST_W:0]   per_inc;
    logic               last_burst;

    phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_c     (cnt_zero_c)
    );

    // Config that would become active at an apply point; a same-cycle cfg_valid_i counts.
    always_comb begin
        cap_high    = (cfg_high_i == '0) ? CNT_W'(1) : cfg_high_i;
        cap_low     = (cfg_low_i == '0) ? CNT_W'(1) : cfg_low_i;
        nxt_high    = cfg_valid_i ? cap_high : (pend_v_q ? pend_high_q : sh_high_q);
        nxt_low     = cfg_valid_i ? cap_low : (pend_v_q ? pend_low_q : sh_low_q);
        a_ticks_nxt = IDLE_LEVEL ? nxt_low : nxt_high;
        b_ticks     = IDLE_LEVEL ? sh_high_q : sh_low_q;
        per_inc     = {1'b0, per_q} + (BURST_W+1)'(1);
        last_burst  = (mode_q == MODE_BURST) && (per_inc == {1'b0, blen_q});
    end

    // Next-state, config bookkeeping and registered output values.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        sh_high_d   = sh_high_q;
        sh_low_d    = sh_low_q;
        pend_high_d = pend_high_q;
        pend_low_d  = pend_low_q;
        pend_v_d    = pend_v_q;
        mode_d      = mode_q;
        blen_d      = blen_q;
        per_d       = per_q;
        stop_d      = stop_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;

        if (cfg_valid_i) begin
            pend_v_d    = 1'b1;
            pend_high_d = cap_high;
            pend_low_d  = cap_low;
            if ((cfg_high_i == '0) || (cfg_low_i == '0)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d = mode_i;
                    blen_d = burst_len_i;
                    per_d  = '0;
                    stop_d = 1'b0;
                    if ((mode_i == MODE_BURST) && (burst_len_i == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        sh_high_d = nxt_high;
                        sh_low_d  = nxt_low;
                        pend_v_d  = 1'b0;
                        state_d   = ST_PH_A;
                        level_d   = ~IDLE_LEVEL;
                        rise_d    = ~IDLE_LEVEL;
                        fall_d    = IDLE_LEVEL;
                        busy_d    = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = a_ticks_nxt - CNT_W'(1);
                    end
                end
            end
            ST_PH_A: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                if (cnt_zero_c) begin
                    state_d  = ST_PH_B;
                    level_d  = IDLE_LEVEL;
                    rise_d   = IDLE_LEVEL;
                    fall_d   = ~IDLE_LEVEL;
                    cnt_load = 1'b1;
                    cnt_val  = b_ticks - CNT_W'(1);
                end
            end
            ST_PH_B: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                if (cnt_zero_c) begin
                    if (last_burst || stop_q || stop_i) begin
                        // Level is already IDLE_LEVEL, so exiting makes no edge.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        sh_high_d = nxt_high;
                        sh_low_d  = nxt_low;
                        pend_v_d  = 1'b0;
                        if (mode_q == MODE_BURST) begin
                            per_d = per_inc[BURST_W-1:0];
                        end
                        state_d  = ST_PH_A;
                        level_d  = ~IDLE_LEVEL;
                        rise_d   = ~IDLE_LEVEL;
                        fall_d   = IDLE_LEVEL;
                        cnt_load = 1'b1;
                        cnt_val  = a_ticks_nxt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            level_q     <= IDLE_LEVEL;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sh_high_q   <= CNT_W'(DEF_HIGH);
            sh_low_q    <= CNT_W'(DEF_LOW);
            pend_high_q <= '0;
            pend_low_q  <= '0;
            pend_v_q    <= 1'b0;
            mode_q      <= MODE_FREE;
            blen_q      <= '0;
            per_q       <= '0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sh_high_q   <= sh_high_d;
            sh_low_q    <= sh_low_d;
            pend_high_q <= pend_high_d;
            pend_low_q  <= pend_low_d;
            pend_v_q    <= pend_v_d;
            mode_q      <= mode_d;
            blen_q      <= blen_d;
            per_q       <= per_d;
            stop_q      <= stop_d;
        end
    end

    assign clk_o      = level_q;
    assign rise_stb_o = rise_q;
    assign fall_stb_o = fall_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cfg_err_o  = err_q;

endmodule

// File: tb/tb_clk_burst_gen.sv
// Scoreboard bench for clk_burst_gen: a period-level model predicts strobe/done events.
module tb_clk_burst_gen;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BURST_W = 4;
    localparam logic        IDLE    = 1'b1;
    localparam int          DEF_H   = 10;
    localparam int          DEF_L   = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic [CNT_W-1:0]   cfg_high, cfg_low;
    logic               cfg_valid, mode, start, stop;
    logic [BURST_W-1:0] burst_len;
    logic               clk_o, rise_stb, fall_stb, busy, done, cfg_err;

    clk_burst_gen #(
        .CNT_W(CNT_W), .BURST_W(BURST_W), .IDLE_LEVEL(IDLE),
        .DEF_HIGH(DEF_H), .DEF_LOW(DEF_L)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cfg_high_i(cfg_high), .cfg_low_i(cfg_low),
        .cfg_valid_i(cfg_valid), .mode_i(mode), .burst_len_i(burst_len),
        .start_i(start), .stop_i(stop), .clk_o(clk_o), .rise_stb_o(rise_stb),
        .fall_stb_o(fall_stb), .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = rise, 1 = fall, 2 = done
    typedef struct { int kind; int cyc; int busy; } ev_t;
    typedef struct { int e; int h; int l; } cfg_t;

    ev_t  exp_q[$];
    ev_t  tmp_q[$];
    cfg_t hist[$];     // cfg writes since last reset, absolute edge numbers
    cfg_t p_cfg[$];    // planned cfg writes of the next run, offsets from start edge
    int   p_stop, p_rst, p_start2;
    bit   err_exp;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Active config at an apply edge: newest write not later than that edge.
    task automatic lookup(input int s, output int h, output int l);
        h = DEF_H;
        l = DEF_L;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].e <= s) begin
                h = hist[i].h;
                l = hist[i].l;
                break;
            end
        end
        if (h == 0) h = 1;
        if (l == 0) l = 1;
    endtask

    // Monitor: every strobe or done pulse consumes one expected event.
    int busy_cnt = 0;
    always @(negedge clk) begin
        int   k;
        ev_t  e;
        if (rise_stb || fall_stb || done) begin
            k = done ? 2 : (rise_stb ? 0 : 1);
            check("single_strobe", int'(rise_stb) + int'(fall_stb) + int'(done), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_event", k, -1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", k, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (k == 2) begin
                    check("busy_span", busy_cnt, e.busy);
                    check("done_level", int'(clk_o), int'(IDLE));
                    check("done_busy", int'(busy), 0);
                end else begin
                    check("edge_level", int'(clk_o), (k == 0) ? 1 : 0);
                    check("edge_busy", int'(busy), 1);
                end
            end
        end
        if (done) busy_cnt = 0;
        else if (busy) busy_cnt++;
        else busy_cnt = 0;
    end

    // Plan one run, push its predicted events, then drive it edge by edge.
    task automatic run(input bit md, input int blen);
        int T, s, p, h, l, a, b, exit_e, endk, last_in, stop_e, rst_e;
        @(negedge clk);
        T = cyc + 1;
        last_in = 0;
        foreach (p_cfg[i]) begin
            hist.push_back('{T + p_cfg[i].e, p_cfg[i].h, p_cfg[i].l});
            if (p_cfg[i].h == 0 || p_cfg[i].l == 0) err_exp = 1'b1;
            if (p_cfg[i].e > last_in) last_in = p_cfg[i].e;
        end
        if (p_stop > last_in) last_in = p_stop;
        if (p_start2 > last_in) last_in = p_start2;
        stop_e = (p_stop >= 0) ? T + p_stop : -1;
        rst_e  = (p_rst >= 0) ? T + p_rst : -1;

        tmp_q.delete();
        s = T;
        p = 0;
        if (md && blen == 0) begin
            tmp_q.push_back('{2, T, 0});
            exit_e = T;
        end else begin
            forever begin
                lookup(s, h, l);
                a = IDLE ? l : h;
                b = IDLE ? h : l;
                tmp_q.push_back('{IDLE ? 1 : 0, s, 0});
                tmp_q.push_back('{IDLE ? 0 : 1, s + a, 0});
                s = s + a + b;
                p++;
                if ((md && p == blen) || (stop_e > T && stop_e <= s) || p >= 1000) begin
                    tmp_q.push_back('{2, s, s - T});
                    exit_e = s;
                    break;
                end
            end
        end
        foreach (tmp_q[i]) begin
            if (rst_e < 0 || tmp_q[i].cyc < rst_e) exp_q.push_back(tmp_q[i]);
        end
        if (rst_e >= 0) begin
            hist.delete();
            err_exp = 1'b0;
            endk = p_rst + 3;
        end else begin
            endk = ((exit_e - T) > last_in ? (exit_e - T) : last_in) + 3;
        end

        for (int k = 0; k <= endk; k++) begin
            if (k > 0) @(negedge clk);
            start     = (k == 0) || (k == p_start2);
            mode      = (k == 0) ? md : 1'b0;
            burst_len = (k == 0) ? BURST_W'(blen) : '0;
            stop      = (k == p_stop);
            rst       = (k == p_rst);
            cfg_valid = 1'b0;
            foreach (p_cfg[i]) begin
                if (p_cfg[i].e == k) begin
                    cfg_valid = 1'b1;
                    cfg_high  = CNT_W'(p_cfg[i].h);
                    cfg_low   = CNT_W'(p_cfg[i].l);
                end
            end
        end
        @(negedge clk);
        {start, stop, rst, cfg_valid, mode} = '0;
        burst_len = '0;
        @(negedge clk);
        check("events_drained", exp_q.size(), 0);
        exp_q.delete();
        check("idle_busy", int'(busy), 0);
        check("idle_clk", int'(clk_o), int'(IDLE));
        check("cfg_err", int'(cfg_err), int'(err_exp));
        p_cfg.delete();
        p_stop = -1;
        p_rst = -1;
        p_start2 = -1;
    endtask

    initial begin
        rst = 1'b1;
        {start, stop, cfg_valid, mode} = '0;
        burst_len = '0;
        cfg_high = '0;
        cfg_low = '0;
        p_stop = -1;
        p_rst = -1;
        p_start2 = -1;
        err_exp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_clk", int'(clk_o), int'(IDLE));
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_strobes", int'(rise_stb) + int'(fall_stb), 0);
        check("rst_err", int'(cfg_err), 0);

        // Burst of 4 periods, high 3 / low 2.
        p_cfg.push_back('{0, 3, 2});
        run(1'b1, 4);

        // Free-run 5/5, retune to 2/7 mid first low phase, then stop.
        p_cfg.push_back('{0, 5, 5});
        p_cfg.push_back('{2, 2, 7});
        p_stop = 15;
        run(1'b0, 0);

        // Zero high count saturates to 1 and sets the sticky error.
        p_cfg.push_back('{0, 0, 3});
        run(1'b1, 2);
        p_cfg.push_back('{0, 4, 4});
        run(1'b1, 1);

        // Zero-length burst; start+stop together; start while busy; stop in idle.
        run(1'b1, 0);
        p_stop = 0;
        p_start2 = 3;
        run(1'b1, 2);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);

        // Reset inside the high phase of a burst, then defaults on restart.
        p_cfg.push_back('{0, 4, 3});
        p_rst = 5;
        run(1'b1, 3);
        run(1'b1, 1);

        // Stop landing exactly at the final burst boundary.
        p_cfg.push_back('{0, 2, 2});
        p_stop = 8;
        run(1'b1, 2);

        // Randomized runs.
        for (int r = 0; r < 24; r++) begin
            int off;
            bit md;
            md = 1'(($urandom % 2));
            off = 0;
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                p_cfg.push_back('{off, int'($urandom_range(0, 6)), int'($urandom_range(0, 6))});
                off += int'($urandom_range(1, 9));
            end
            if (!md || ($urandom % 2) == 1) p_stop = int'($urandom_range(1, 40));
            run(md, int'($urandom_range(0, 5)));
        end

        // Maximum tick counts and burst length.
        p_cfg.push_back('{0, 255, 255});
        run(1'b1, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
